// File: rtl/crc_lfsr_pkg.sv
// Shared constants and FSM state type for the serial TLP-header CRC.
// Frame layout: {pad, tlp, crc} packed into FRAME_W bits.
package crc_lfsr_pkg;
  localparam int WIDTH   = 16;
  localparam int DATA_W  = 96;
  localparam int FRAME_W = 128;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int PAD_W   = FRAME_W - DATA_W - WIDTH;

  localparam logic [WIDTH-1:0] POLY = 16'h1021;
  localparam logic [WIDTH-1:0] INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;
endpackage

// File: rtl/crc_lfsr_core.sv
// Bare Galois LFSR step register: seed load, enable, one serial bit in.
// Load wins over enable.
module crc_lfsr_core
  import crc_lfsr_pkg::*;
#(
  parameter int                LFSR_W = WIDTH,
  parameter logic [LFSR_W-1:0] TAPS   = POLY,
  parameter logic [LFSR_W-1:0] SEED   = INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic              din,
  output logic [LFSR_W-1:0] q
);

  logic fb;
  logic [LFSR_W-1:0] step;

  assign fb   = q[LFSR_W-1] ^ din;
  assign step = {q[LFSR_W-2:0], 1'b0} ^ (fb ? TAPS : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= SEED;
    end else if (en) begin
      q <= step;
    end
  end

endmodule

// File: rtl/crc_lfsr.sv
// Serial CRC-16/CCITT over a captured 96-bit TLP header, MSB first.
// Presents {pad, tlp, crc} on crc_out once rdy is high.
module crc_lfsr
  import crc_lfsr_pkg::*;
#(
  parameter logic [WIDTH-1:0] POLY = crc_lfsr_pkg::POLY,
  parameter logic [WIDTH-1:0] INIT = crc_lfsr_pkg::INIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [DATA_W-1:0]  tlp_in,
  output logic [WIDTH-1:0]   lfsr_q,
  output logic               rdy,
  output logic [FRAME_W-1:0] crc_out
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] held_tlp;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              last;

  assign busy = (state_q == BUSY);
  assign last = (count == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A start strobe restarts from any state, ahead of shifting.
  always_comb begin
    state_d = state_q;
    if (we) begin
      state_d = BUSY;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        BUSY: state_d = last ? DONE : BUSY;
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sr  <= '0;
      held_tlp <= '0;
      count    <= '0;
    end else if (we) begin
      data_sr  <= tlp_in;
      held_tlp <= tlp_in;
      count    <= '0;
    end else if (busy) begin
      data_sr  <= data_sr << 1;
      count    <= count + 1'b1;
    end
  end

  crc_lfsr_core #(
    .LFSR_W (WIDTH),
    .TAPS   (POLY),
    .SEED   (INIT)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (we),
    .en   (busy && !we),
    .din  (data_sr[DATA_W-1]),
    .q    (lfsr_q)
  );

  assign rdy     = (state_q == DONE);
  assign crc_out = rdy ? {{PAD_W{1'b0}}, held_tlp, lfsr_q}
                       : '0;

endmodule

// File: tb/tb_crc_lfsr.sv
// Randomized bench for crc_lfsr against a byte-wise CCITT-FALSE model.
// Two instances share stimulus: default seed and zero seed.
module tb_crc_lfsr;

  logic         clk;
  logic         rst;
  logic         we;
  logic [95:0]  tlp_in;
  logic [15:0]  lfsr_a, lfsr_z;
  logic         rdy_a, rdy_z;
  logic [127:0] out_a, out_z;

  int n_vec;
  int n_bad;

  crc_lfsr dut_a (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .tlp_in  (tlp_in),
    .lfsr_q  (lfsr_a),
    .rdy     (rdy_a),
    .crc_out (out_a)
  );

  crc_lfsr #(
    .INIT (16'h0000)
  ) dut_z (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .tlp_in  (tlp_in),
    .lfsr_q  (lfsr_z),
    .rdy     (rdy_z),
    .crc_out (out_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Standard byte-at-a-time CRC-16/CCITT, no reflection, no xorout.
  function automatic logic [15:0] crc_ref(input logic [95:0] d,
                                          input logic [15:0] init);
    logic [15:0] c;
    c = init;
    for (int k = 11; k >= 0; k--) begin
      c ^= {d[k*8 +: 8], 8'h00};
      for (int b = 0; b < 8; b++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Caller sits at a negedge; returns at the negedge after edge 0.
  task automatic start_run(input logic [95:0] d);
    we     = 1'b1;
    tlp_in = d;
    @(negedge clk);
    we     = 1'b0;
  endtask

  task automatic finish_run(input logic [95:0] d, input bit scramble);
    logic [15:0] ca, cz;
    ca = crc_ref(d, 16'hFFFF);
    cz = crc_ref(d, 16'h0000);
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk);
      if (i < 96) begin
        check("rdy_early_a", 128'(rdy_a), 128'd0);
        check("rdy_early_z", 128'(rdy_z), 128'd0);
        if (scramble) tlp_in = rand96();
      end
    end
    for (int h = 0; h < 3; h++) begin
      check("rdy_a", 128'(rdy_a), 128'd1);
      check("rdy_z", 128'(rdy_z), 128'd1);
      check("frame_a", out_a, {16'h0, d, ca});
      check("frame_z", out_z, {16'h0, d, cz});
      check("lfsr_a", 128'(lfsr_a), 128'(ca));
      @(negedge clk);
      tlp_in = rand96();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_lfsr"}, 128'({lfsr_a, lfsr_z}), 128'd0);
    check({tag, "_rdy"}, 128'({rdy_a, rdy_z}), 128'd0);
    check({tag, "_out_a"}, out_a, 128'd0);
    check({tag, "_out_z"}, out_z, 128'd0);
  endtask

  initial begin
    logic [95:0] da, db;
    n_vec  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    we     = 1'b0;
    tlp_in = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset_init");
    rst = 1'b0;
    @(negedge clk);

    start_run(96'h0);
    finish_run(96'h0, 1'b0);
    check("zero_seed_zero", out_z, 128'h0);

    start_run(96'h1);
    finish_run(96'h1, 1'b0);
    check("zero_seed_one", out_z, {16'h0, 96'h1, 16'h1021});

    start_run(96'h123456789abcdefffff12345);
    finish_run(96'h123456789abcdefffff12345, 1'b1);

    // Asynchronous reset mid-cycle while holding a result.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_cleared("reset_async");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_cleared("reset_hold");
    end
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      da = rand96();
      start_run(da);
      finish_run(da, r[0]);
    end

    // Restart at edge 40 of run A with data B.
    da = rand96();
    db = rand96();
    start_run(da);
    repeat (39) @(negedge clk);
    start_run(db);
    finish_run(db, 1'b1);

    // Reset at edge 50, then a fresh run.
    da = rand96();
    db = rand96();
    start_run(da);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1 check_cleared("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_run(db);
    finish_run(db, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
